sprite_renderer: RTL and testbench

- Downstream consumer of the video sync generator's timing. Draws one monochrome SPRITE_W x SPRITE_H sprite per frame.
- Each scanline:
  - fetches one bitmap row from a shared sprite ROM over a req/ack handshake during horizontal blank;
  - buffers the row;
  - shifts it out as a 1-bit pixel stream when the beam reaches the sprite's X position.
- Top level derives vstart/load/hstart strobes from hpos/vpos comparisons against sprite coordinates.

---
 rtl/sprite_renderer.sv | 165 ++++++++++++++++
 tb/tb_sprite_renderer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_renderer.sv
// Monochrome sprite line renderer: fetches one ROM row per scanline in hblank, then streams it as pixels.
// Optional build macro SPRITE_RENDERER_HMIRROR_EN adds an hmirror input for LSB-first (mirrored) drawing.
module sprite_renderer #(
  parameter int SPRITE_W = 8,
  parameter int SPRITE_H = 16,
  parameter int ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                vstart,
  input  logic                load,
  input  logic                hstart,
`ifdef SPRITE_RENDERER_HMIRROR_EN
  input  logic                hmirror,
`endif
  output logic                rom_req,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic                rom_ack,
  input  logic [SPRITE_W-1:0] rom_bits,
  output logic                gfx,
  output logic                in_progress
);

  localparam int XW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_LOAD   = 3'd1,
    LOAD_REQ    = 3'd2,
    WAIT_HSTART = 3'd3,
    DRAW        = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ycount_q, ycount_d;
  logic [XW-1:0]       xcount_q, xcount_d;
  logic [SPRITE_W-1:0] row_q, row_d;
  logic                rom_req_q, rom_req_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic                gfx_q, gfx_d;
  logic                in_progress_q, in_progress_d;
  logic                mirror_q, mirror_d;
  logic                mirror_in;

`ifdef SPRITE_RENDERER_HMIRROR_EN
  assign mirror_in = hmirror;
`else
  assign mirror_in = 1'b0;
`endif

  function automatic logic pix_sel(input logic [SPRITE_W-1:0] row,
                                   input logic [XW-1:0]       idx,
                                   input logic                mir);
    logic [XW-1:0] rev;
    rev = XW'(SPRITE_W - 1) - idx;
    if (mir) begin
      pix_sel = row[idx];
    end else begin
      pix_sel = row[rev];
    end
  endfunction

  // Next-state and next-output logic; gfx is precomputed one cycle ahead so it leaves a flop.
  always_comb begin
    state_d    = state_q;
    ycount_d   = ycount_q;
    xcount_d   = xcount_q;
    row_d      = row_q;
    rom_req_d  = rom_req_q;
    rom_addr_d = rom_addr_q;
    gfx_d      = 1'b0;
    mirror_d   = mirror_q;
    if (vstart) begin
      // Frame resync wins over every other strobe, in any state.
      ycount_d  = '0;
      rom_req_d = 1'b0;
      state_d   = WAIT_LOAD;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        WAIT_LOAD: begin
          if (load) begin
            rom_req_d  = 1'b1;
            rom_addr_d = ycount_q;
            state_d    = LOAD_REQ;
          end else begin
            state_d = WAIT_LOAD;
          end
        end
        LOAD_REQ: begin
          if (rom_ack) begin
            row_d     = rom_bits;
            rom_req_d = 1'b0;
            state_d   = WAIT_HSTART;
          end else begin
            state_d = LOAD_REQ;
          end
        end
        WAIT_HSTART: begin
          if (hstart) begin
            xcount_d = '0;
            mirror_d = mirror_in;
            gfx_d    = pix_sel(row_q, XW'(0), mirror_in);
            state_d  = DRAW;
          end else begin
            state_d = WAIT_HSTART;
          end
        end
        DRAW: begin
          if (xcount_q == XW'(SPRITE_W - 1)) begin
            if (ycount_q == ADDR_W'(SPRITE_H - 1)) begin
              ycount_d = '0;
              state_d  = IDLE;
            end else begin
              ycount_d = ycount_q + ADDR_W'(1);
              state_d  = WAIT_LOAD;
            end
          end else begin
            xcount_d = xcount_q + XW'(1);
            gfx_d    = pix_sel(row_q, xcount_q + XW'(1), mirror_q);
            state_d  = DRAW;
          end
        end
        default: begin
          rom_req_d = 1'b0;
          state_d   = IDLE;
        end
      endcase
    end
    in_progress_d = (state_d != IDLE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      ycount_q      <= '0;
      xcount_q      <= '0;
      row_q         <= '0;
      rom_req_q     <= 1'b0;
      rom_addr_q    <= '0;
      gfx_q         <= 1'b0;
      in_progress_q <= 1'b0;
      mirror_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      ycount_q      <= ycount_d;
      xcount_q      <= xcount_d;
      row_q         <= row_d;
      rom_req_q     <= rom_req_d;
      rom_addr_q    <= rom_addr_d;
      gfx_q         <= gfx_d;
      in_progress_q <= in_progress_d;
      mirror_q      <= mirror_d;
    end
  end

  assign rom_req     = rom_req_q;
  assign rom_addr    = rom_addr_q;
  assign gfx         = gfx_q;
  assign in_progress = in_progress_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// Directed self-checking bench for sprite_renderer (default 8x16 geometry).
module tb_sprite_renderer;

  logic       clk = 1'b0;
  logic       reset;
  logic       vstart, load, hstart, rom_ack, hmirror;
  logic [7:0] rom_bits;
  logic       rom_req, gfx, in_progress;
  logic [3:0] rom_addr;

  int checks = 0;
  int errors = 0;

  sprite_renderer dut (
    .clk(clk),
    .reset(reset),
    .vstart(vstart),
    .load(load),
    .hstart(hstart),
`ifdef SPRITE_RENDERER_HMIRROR_EN
    .hmirror(hmirror),
`endif
    .rom_req(rom_req),
    .rom_addr(rom_addr),
    .rom_ack(rom_ack),
    .rom_bits(rom_bits),
    .gfx(gfx),
    .in_progress(in_progress)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_vstart();
    vstart = 1'b1;
    tick();
    vstart = 1'b0;
  endtask

  // Request a row, hold ack off for dly cycles, then ack with bits.
  task automatic fetch(input logic [3:0] addr, input logic [7:0] bits, input int dly);
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("req_rise", {31'd0, rom_req}, 32'd1);
    chk("req_addr", {28'd0, rom_addr}, {28'd0, addr});
    for (int i = 0; i < dly; i++) begin
      tick();
      chk("req_hold", {31'd0, rom_req}, 32'd1);
      chk("addr_hold", {28'd0, rom_addr}, {28'd0, addr});
    end
    rom_ack  = 1'b1;
    rom_bits = bits;
    tick();
    rom_ack  = 1'b0;
    rom_bits = 8'h00;
    chk("req_drop", {31'd0, rom_req}, 32'd0);
  endtask

  // Strobe hstart and check the 8 pixels (seq[7] first) then the trailing zero.
  task automatic draw(input string tag, input logic [7:0] seq, input logic hm);
    hmirror = hm;
    hstart  = 1'b1;
    tick();
    hstart  = 1'b0;
    hmirror = ~hm;
    for (int i = 0; i < 8; i++) begin
      chk(tag, {31'd0, gfx}, {31'd0, seq[7-i]});
      tick();
    end
    chk({tag, "_end"}, {31'd0, gfx}, 32'd0);
  endtask

  initial begin
    reset = 1'b0; vstart = 1'b0; load = 1'b0; hstart = 1'b0;
    rom_ack = 1'b0; rom_bits = 8'h00; hmirror = 1'b0;

    // Reset held with random strobes
    for (int i = 0; i < 3; i++) begin
      vstart = 1'($urandom); load = 1'($urandom); hstart = 1'($urandom);
      rom_ack = 1'($urandom); rom_bits = 8'($urandom);
      tick();
      chk("rst_gfx", {31'd0, gfx}, 32'd0);
      chk("rst_req", {31'd0, rom_req}, 32'd0);
      chk("rst_inprog", {31'd0, in_progress}, 32'd0);
      chk("rst_addr", {28'd0, rom_addr}, 32'd0);
    end
    vstart = 1'b0; load = 1'b0; hstart = 1'b0; rom_ack = 1'b0; rom_bits = 8'h00;
    reset = 1'b1;
    tick();
    chk("idle_inprog", {31'd0, in_progress}, 32'd0);

    // Strobes in IDLE are ignored
    load = 1'b1; hstart = 1'b1; rom_ack = 1'b1;
    tick();
    load = 1'b0; hstart = 1'b0; rom_ack = 1'b0;
    chk("idle_ignore_req", {31'd0, rom_req}, 32'd0);
    chk("idle_ignore_inprog", {31'd0, in_progress}, 32'd0);

    // Full sprite, rows A5^r, ack two cycles after request
    pulse_vstart();
    chk("vstart_inprog", {31'd0, in_progress}, 32'd1);
    fetch(4'd0, 8'hA5, 1);
    draw("row0", 8'b1010_0101, 1'b0);
    for (int r = 1; r < 16; r++) begin
      fetch(4'(r), 8'hA5 ^ 8'(r), 1);
      draw("rowN", 8'hA5 ^ 8'(r), 1'b0);
      if (r < 15) chk("frame_inprog", {31'd0, in_progress}, 32'd1);
    end
    chk("frame_done_idle", {31'd0, in_progress}, 32'd0);

    // Handshake hold for 20 cycles
    pulse_vstart();
    fetch(4'd0, 8'h3C, 20);
    draw("hold_row", 8'b0011_1100, 1'b0);

    // Late ack: hstart while still in LOAD_REQ
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("late_addr", {28'd0, rom_addr}, 32'd1);
    hstart = 1'b1;
    tick();
    hstart = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk("late_gfx_zero", {31'd0, gfx}, 32'd0);
      tick();
    end
    rom_ack = 1'b1; rom_bits = 8'hF0;
    tick();
    rom_ack = 1'b0; rom_bits = 8'h00;
    chk("late_req_drop", {31'd0, rom_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("late_gap_zero", {31'd0, gfx}, 32'd0);
    end
    draw("late_row", 8'b1111_0000, 1'b0);

    // Resync on 4th DRAW cycle of row 5
    pulse_vstart();
    for (int r = 0; r < 5; r++) begin
      fetch(4'(r), 8'h11 * 8'(r + 1), 0);
      draw("pre_rows", 8'h11 * 8'(r + 1), 1'b0);
    end
    fetch(4'd5, 8'hFF, 0);
    hstart = 1'b1;
    tick();
    hstart = 1'b0;
    tick(); tick(); tick();
    chk("draw4_gfx", {31'd0, gfx}, 32'd1);
    vstart = 1'b1;
    tick();
    vstart = 1'b0;
    chk("resync_gfx", {31'd0, gfx}, 32'd0);
    chk("resync_inprog", {31'd0, in_progress}, 32'd1);
    tick();
    chk("resync_gfx_stays", {31'd0, gfx}, 32'd0);

    // Resync mid-handshake; stale ack and hstart then ignored
    load = 1'b1;
    tick();
    load = 1'b0;
    chk("resync_addr0", {28'd0, rom_addr}, 32'd0);
    chk("resync_req", {31'd0, rom_req}, 32'd1);
    vstart = 1'b1; rom_ack = 1'b1; rom_bits = 8'hFF;
    tick();
    vstart = 1'b0; rom_ack = 1'b0;
    chk("hs_resync_req", {31'd0, rom_req}, 32'd0);
    rom_ack = 1'b1;
    tick();
    rom_ack = 1'b0; rom_bits = 8'h00;
    hstart = 1'b1;
    tick();
    hstart = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("stale_gfx_zero", {31'd0, gfx}, 32'd0);
      tick();
    end
    chk("stale_req_zero", {31'd0, rom_req}, 32'd0);

    // vstart beats load in the same cycle
    vstart = 1'b1; load = 1'b1;
    tick();
    vstart = 1'b0; load = 1'b0;
    chk("vstart_wins_req", {31'd0, rom_req}, 32'd0);
    fetch(4'd0, 8'h81, 0);
    draw("post_resync", 8'b1000_0001, 1'b0);

`ifdef SPRITE_RENDERER_HMIRROR_EN
    // Mirror on/off with row C1
    fetch(4'd1, 8'hC1, 0);
    draw("mirror_on", 8'b1000_0011, 1'b1);
    fetch(4'd2, 8'hC1, 0);
    draw("mirror_off", 8'b1100_0001, 1'b0);
`endif

    // Asynchronous reset mid-draw
    fetch(4'(dut.ycount_q), 8'hFF, 0);
    hstart = 1'b1;
    tick();
    hstart = 1'b0;
    chk("pre_areset_gfx", {31'd0, gfx}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("areset_gfx", {31'd0, gfx}, 32'd0);
    chk("areset_inprog", {31'd0, in_progress}, 32'd0);
    chk("areset_addr", {28'd0, rom_addr}, 32'd0);
    reset = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
